sensor_calib_scheduler: RTL and testbench

//  Sequences delay-line sensor calibration over N_SENSORS sensors in the system_clk domain.
//  For each enabled sensor it sets sens_calib_id, pulses calib_trg and waits for settling.
//  It then checks the sensor's thermometer popcount against a window and retries if outside it.

---
 rtl/sensor_calib_scheduler_if.sv | 36 +++
 rtl/sensor_calib_scheduler.sv | 142 ++++++++++++++
 tb/tb_sensor_calib_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_calib_scheduler_if.sv
// Control/status bundle between the calibration scheduler and its controller.
// The slave side is the scheduler; the master side drives start/abort/mask/window/sample.
interface sensor_calib_scheduler_if #(
  parameter int N_SENSORS    = 5,
  parameter int SENSOR_WIDTH = 16
);
  localparam int IDW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int CW  = $clog2(SENSOR_WIDTH + 1);

  logic                    start_i;
  logic                    abort_i;
  logic [N_SENSORS-1:0]    calib_mask_i;
  logic [CW-1:0]           target_lo_i;
  logic [CW-1:0]           target_hi_i;
  logic [SENSOR_WIDTH-1:0] sensor_data_i;
  logic [IDW-1:0]          sens_calib_o;
  logic                    calib_trg_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    aborted_o;
  logic [N_SENSORS-1:0]    pass_mask_o;
  logic [N_SENSORS-1:0]    fail_mask_o;
  logic [CW-1:0]           last_count_o;

  modport master (
    output start_i, abort_i, calib_mask_i, target_lo_i, target_hi_i, sensor_data_i,
    input  sens_calib_o, calib_trg_o, busy_o, done_o, aborted_o,
           pass_mask_o, fail_mask_o, last_count_o
  );

  modport slave (
    input  start_i, abort_i, calib_mask_i, target_lo_i, target_hi_i, sensor_data_i,
    output sens_calib_o, calib_trg_o, busy_o, done_o, aborted_o,
           pass_mask_o, fail_mask_o, last_count_o
  );
endinterface

// File: rtl/sensor_calib_scheduler.sv
// Walks the enabled sensors, triggers calibration, waits for settling and checks the
// thermometer popcount against an inclusive window, retrying up to MAX_TRIES times.
module sensor_calib_scheduler #(
  parameter int N_SENSORS     = 5,
  parameter int SENSOR_WIDTH  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_TRIES     = 3
) (
  input  logic system_clk,
  input  logic reset_n,
  sensor_calib_scheduler_if.slave bus
);
  localparam int IDW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int CW  = $clog2(SENSOR_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SELECT, TRIG, SETTLE, SAMPLE, NEXT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [N_SENSORS-1:0] mask_reg, pass_reg, fail_reg;
  logic [IDW-1:0]       idx_reg, sens_reg;
  logic [3:0]           tries_reg;
  logic [7:0]           settle_reg;
  logic [CW-1:0]        last_reg;
  logic                 trg_reg, busy_reg, done_reg, aborted_reg;

  logic [N_SENSORS-1:0] from_idx, after_idx;
  logic                 found, has_after, in_window, abort_taken;
  logic [IDW-1:0]       sel_id;
  logic [CW-1:0]        cnt;

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_cand
      localparam logic [IDW-1:0] ID = IDW'(gi);
      assign from_idx[gi]  = mask_reg[gi] && (ID >= idx_reg);
      assign after_idx[gi] = mask_reg[gi] && (ID > idx_reg);
    end
  endgenerate

  // Lowest enabled id at or above idx; higher indices are overridden by lower ones.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (from_idx[i]) begin
        found  = 1'b1;
        sel_id = IDW'(i);
      end
    end
  end

  assign has_after = |after_idx;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < SENSOR_WIDTH; i++) cnt = cnt + CW'(bus.sensor_data_i[i]);
  end

  assign in_window   = (cnt >= bus.target_lo_i) && (cnt <= bus.target_hi_i);
  assign abort_taken = bus.abort_i && (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (bus.start_i) state_next = (bus.calib_mask_i == '0) ? DONE : SELECT;
      SELECT: state_next = found ? TRIG : DONE;
      TRIG:   state_next = SETTLE;
      SETTLE: if (settle_reg == 8'd0) state_next = SAMPLE;
      SAMPLE: begin
        if (in_window)                      state_next = NEXT;
        else if (tries_reg < 4'(MAX_TRIES)) state_next = TRIG;
        else                                state_next = NEXT;
      end
      // Finishing straight from NEXT when no enabled sensor remains keeps the
      // pass length at exactly SETTLE_CYCLES+4 cycles per enabled sensor.
      NEXT:   state_next = has_after ? SELECT : DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_taken) state_next = IDLE;
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      pass_reg    <= '0;
      fail_reg    <= '0;
      idx_reg     <= '0;
      sens_reg    <= '0;
      tries_reg   <= '0;
      settle_reg  <= '0;
      last_reg    <= '0;
      trg_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      trg_reg     <= (state_next == TRIG);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == DONE);
      aborted_reg <= abort_taken;
      if (!abort_taken) begin
        case (state_reg)
          IDLE: if (bus.start_i) begin
            mask_reg <= bus.calib_mask_i;
            pass_reg <= '0;
            fail_reg <= '0;
            last_reg <= '0;
            idx_reg  <= '0;
          end
          SELECT: if (found) begin
            idx_reg   <= sel_id;
            sens_reg  <= sel_id;
            tries_reg <= '0;
          end
          TRIG: begin
            tries_reg  <= tries_reg + 4'd1;
            settle_reg <= 8'(SETTLE_CYCLES - 1);
          end
          SETTLE: if (settle_reg != 8'd0) settle_reg <= settle_reg - 8'd1;
          SAMPLE: begin
            last_reg <= cnt;
            if (in_window)                        pass_reg[idx_reg] <= 1'b1;
            else if (tries_reg >= 4'(MAX_TRIES)) fail_reg[idx_reg] <= 1'b1;
          end
          NEXT: if (has_after) idx_reg <= idx_reg + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.sens_calib_o = sens_reg;
  assign bus.calib_trg_o  = trg_reg;
  assign bus.busy_o       = busy_reg;
  assign bus.done_o       = done_reg;
  assign bus.aborted_o    = aborted_reg;
  assign bus.pass_mask_o  = pass_reg;
  assign bus.fail_mask_o  = fail_reg;
  assign bus.last_count_o = last_reg;
endmodule

// File: tb/tb_sensor_calib_scheduler.sv
// Directed bench: stimulus pushes expected trigger/done/abort events with their cycle
// numbers into a scoreboard queue; a negedge monitor pops and compares each DUT event.
module tb_sensor_calib_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_calib_scheduler_if #(.N_SENSORS(5), .SENSOR_WIDTH(16)) bus ();

  sensor_calib_scheduler #(
    .N_SENSORS(5), .SENSOR_WIDTH(16), .SETTLE_CYCLES(4), .MAX_TRIES(3)
  ) dut (
    .system_clk(clk),
    .reset_n   (rst_n),
    .bus       (bus.slave)
  );

  typedef struct {
    int kind;      // 0 trigger, 1 done, 2 aborted
    int cyc;
    int id;
    int pass;
    int fail;
    int last;      // -1: not compared
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   t0 = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   trg_seen = 0;
  int   mode = 0;
  logic [15:0] pat = 16'h00FF;

  always @(posedge clk) cyc++;

  // Sensor model: mode 1 returns count 2 on the first trigger, count 8 afterwards.
  always_comb begin
    bus.sensor_data_i = pat;
    if (mode == 1) bus.sensor_data_i = (trg_seen < 2) ? 16'h0003 : 16'h00FF;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc - t0);
    end
  endtask

  task automatic push(input int kind, input int c, input int id,
                      input int pass, input int fail, input int last);
    exp_t e;
    e.kind = kind; e.cyc = t0 + c; e.id = id; e.pass = pass; e.fail = fail; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc - t0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc - t0, e.cyc - t0);
      if (kind == 0) check("trig_id", int'(bus.sens_calib_o), e.id);
      if (kind != 0) begin
        check("pass_mask", int'(bus.pass_mask_o), e.pass);
        check("fail_mask", int'(bus.fail_mask_o), e.fail);
        check("mask_overlap", int'(bus.pass_mask_o & bus.fail_mask_o), 0);
      end
      if (kind == 1 && e.last >= 0) check("last_count", int'(bus.last_count_o), e.last);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.calib_trg_o) begin
        trg_seen++;
        observe(0);
      end
      if (bus.done_o)    observe(1);
      if (bus.aborted_o) observe(2);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pass(input logic [4:0] m, input int lo, input int hi);
    bus.calib_mask_i = m;
    bus.target_lo_i  = 5'(lo);
    bus.target_hi_i  = 5'(hi);
    trg_seen = 0;
    bus.start_i = 1'b1;
    t0 = cyc;
    goto(cyc + 1);
    bus.start_i = 1'b0;
  endtask

  task automatic finish_pass(input string name, input int c);
    goto(t0 + c);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_busy_low"}, int'(bus.busy_o), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.calib_mask_i = '0;
    bus.target_lo_i = 5'd4;
    bus.target_hi_i = 5'd12;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy_o), 0);
    check("reset_trg", int'(bus.calib_trg_o), 0);
    check("reset_done", int'(bus.done_o), 0);
    check("reset_pass", int'(bus.pass_mask_o), 0);
    check("reset_last", int'(bus.last_count_o), 0);
    rst_n = 1'b1;
    goto(cyc + 2);

    // 1: all five sensors, count 8 in 4..12
    start_pass(5'b11111, 4, 12);
    for (int k = 0; k < 5; k++) push(0, 2 + 8 * k, k, 0, 0, -1);
    push(1, 41, 0, 5'b11111, 0, 8);
    finish_pass("all5", 44);

    // 2: sparse mask, disabled ids skipped
    start_pass(5'b10101, 4, 12);
    push(0, 2, 0, 0, 0, -1);
    push(0, 10, 2, 0, 0, -1);
    push(0, 18, 4, 0, 0, -1);
    push(1, 25, 0, 5'b10101, 0, 8);
    finish_pass("sparse", 28);

    // 3: sensor 1 saturated, exhausts its three tries
    pat = 16'hFFFF;
    start_pass(5'b00010, 4, 12);
    push(0, 2, 1, 0, 0, -1);
    push(0, 8, 1, 0, 0, -1);
    push(0, 14, 1, 0, 0, -1);
    push(1, 21, 0, 0, 5'b00010, 16);
    finish_pass("exhaust", 24);

    // 4: sensor 0 low on first try, in window on retry
    mode = 1;
    start_pass(5'b00001, 4, 12);
    push(0, 2, 0, 0, 0, -1);
    push(0, 8, 0, 0, 0, -1);
    push(1, 15, 0, 5'b00001, 0, 8);
    finish_pass("retry", 18);
    mode = 0;

    // 5: empty mask, count on each bound, inverted window
    start_pass(5'b00000, 4, 12);
    push(1, 1, 0, 0, 0, -1);
    finish_pass("empty", 4);

    pat = 16'h000F;
    start_pass(5'b00001, 4, 12);
    push(0, 2, 0, 0, 0, -1);
    push(1, 9, 0, 5'b00001, 0, 4);
    finish_pass("at_lo", 12);

    pat = 16'h0FFF;
    start_pass(5'b00100, 4, 12);
    push(0, 2, 2, 0, 0, -1);
    push(1, 9, 0, 5'b00100, 0, 12);
    finish_pass("at_hi", 12);

    pat = 16'h00FF;
    start_pass(5'b00011, 9, 3);
    push(0, 2, 0, 0, 0, -1);
    push(0, 8, 0, 0, 0, -1);
    push(0, 14, 0, 0, 0, -1);
    push(0, 22, 1, 0, 0, -1);
    push(0, 28, 1, 0, 0, -1);
    push(0, 34, 1, 0, 0, -1);
    push(1, 41, 0, 0, 5'b00011, 8);
    finish_pass("inverted", 44);

    // 6a: abort in SETTLE of sensor 2; a start while busy is ignored
    start_pass(5'b11111, 4, 12);
    push(0, 2, 0, 0, 0, -1);
    push(0, 10, 1, 0, 0, -1);
    push(0, 18, 2, 0, 0, -1);
    push(2, 21, 0, 5'b00011, 0, -1);
    goto(t0 + 5);
    bus.calib_mask_i = 5'b00000;
    bus.start_i = 1'b1;
    goto(t0 + 6);
    bus.start_i = 1'b0;
    goto(t0 + 20);
    bus.abort_i = 1'b1;
    goto(t0 + 21);
    bus.abort_i = 1'b0;
    check("abort_busy", int'(bus.busy_o), 0);
    check("abort_trg_low", int'(bus.calib_trg_o), 0);
    finish_pass("abort", 30);

    // 6b: asynchronous reset mid-pass
    start_pass(5'b11111, 4, 12);
    push(0, 2, 0, 0, 0, -1);
    push(0, 10, 1, 0, 0, -1);
    goto(t0 + 12);
    check("pre_reset_last", int'(bus.last_count_o), 8);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", int'(bus.busy_o), 0);
    check("async_pass", int'(bus.pass_mask_o), 0);
    check("async_id", int'(bus.sens_calib_o), 0);
    check("async_last", int'(bus.last_count_o), 0);
    check("reset_queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    goto(cyc + 10);
    check("post_reset_busy", int'(bus.busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
